// File: rtl/prog_mem_pkg.sv
// Shared definitions for the loadable program memory: default geometry and
// controller state encodings.
package prog_mem_pkg;

    localparam int unsigned INSTRUCTION_WIDTH = 32;
    localparam int unsigned PM_DATA_WIDTH     = INSTRUCTION_WIDTH;
    localparam int unsigned PM_ADDR_WIDTH     = 5;

    typedef logic [1:0] pm_state_t;

    localparam pm_state_t PM_IDLE    = 2'd0;
    localparam pm_state_t PM_LOADING = 2'd1;
    localparam pm_state_t PM_READY   = 2'd2;

endpackage

// File: rtl/prog_mem_if.sv
// Load-stream and fetch-port bundle between the loader/fetch stage (master)
// and the program memory (slave).
interface prog_mem_if
    import prog_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = PM_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = PM_ADDR_WIDTH
) ();

    logic                  load_start;
    logic                  load_valid;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  load_last;
    logic                  load_ready;
    logic [ADDR_WIDTH:0]   prog_len;
    logic                  ready;
    logic                  fetch_req;
    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic                  fetch_valid;
    logic [DATA_WIDTH-1:0] fetch_data;
    logic                  fetch_oob;
    logic                  fetch_err;

    modport master (
        output load_start, load_valid, load_data, load_last, fetch_req, fetch_addr,
        input  load_ready, prog_len, ready, fetch_valid, fetch_data, fetch_oob, fetch_err
    );

    modport slave (
        input  load_start, load_valid, load_data, load_last, fetch_req, fetch_addr,
        output load_ready, prog_len, ready, fetch_valid, fetch_data, fetch_oob, fetch_err
    );

endinterface

// File: rtl/prog_mem_sp_ram_1w1r.sv
// DEPTH x DATA_WIDTH RAM: synchronous write port, registered read port.
// A read and write to the same address in one cycle returns the old word.
module sp_ram_1w1r #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/prog_mem.sv
// Loadable program memory: load-stream controller, program length tracking
// and a one-cycle registered fetch port over sp_ram_1w1r.
module prog_mem
    import prog_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = PM_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = PM_ADDR_WIDTH
) (
    input  logic       clk,
    input  logic       rst,
    prog_mem_if.slave  bus
);

    pm_state_t             state_q, state_d;
    logic [ADDR_WIDTH-1:0] load_ptr_q, load_ptr_d;
    logic [ADDR_WIDTH:0]   prog_len_q, prog_len_d;
    logic                  fetch_valid_q, fetch_valid_d;
    logic                  fetch_oob_q, fetch_oob_d;
    logic                  fetch_err_q, fetch_err_d;
    logic                  data_zero_q, data_zero_d;
    logic                  wr_en;
    logic                  fetch_acc;
    logic [DATA_WIDTH-1:0] rd_data;

    always_comb begin
        state_d       = state_q;
        load_ptr_d    = load_ptr_q;
        prog_len_d    = prog_len_q;
        fetch_valid_d = 1'b0;
        fetch_oob_d   = 1'b0;
        fetch_err_d   = 1'b0;
        data_zero_d   = data_zero_q;
        wr_en         = 1'b0;
        fetch_acc     = 1'b0;

        // Fetch is decided on the current state, so a fetch coinciding with
        // load_start in READY still sees the old program.
        if (bus.fetch_req) begin
            if (state_q == PM_READY) begin
                fetch_acc     = 1'b1;
                fetch_valid_d = 1'b1;
                fetch_oob_d   = ({1'b0, bus.fetch_addr} >= prog_len_q);
                data_zero_d   = 1'b0;
            end else begin
                fetch_err_d   = 1'b1;
                data_zero_d   = 1'b1;
            end
        end

        case (state_q)
            PM_IDLE, PM_READY: begin
                if (bus.load_start) begin
                    state_d    = PM_LOADING;
                    load_ptr_d = '0;
                    prog_len_d = '0;
                end
            end
            PM_LOADING: begin
                if (bus.load_start) begin
                    load_ptr_d = '0;
                    prog_len_d = '0;
                end else if (bus.load_valid) begin
                    wr_en      = 1'b1;
                    load_ptr_d = load_ptr_q + ADDR_WIDTH'(1);
                    prog_len_d = prog_len_q + (ADDR_WIDTH + 1)'(1);
                    if (bus.load_last || (&load_ptr_q)) begin
                        state_d = PM_READY;
                    end
                end
            end
            default: state_d = PM_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= PM_IDLE;
            load_ptr_q    <= '0;
            prog_len_q    <= '0;
            fetch_valid_q <= 1'b0;
            fetch_oob_q   <= 1'b0;
            fetch_err_q   <= 1'b0;
            data_zero_q   <= 1'b1;
        end else begin
            state_q       <= state_d;
            load_ptr_q    <= load_ptr_d;
            prog_len_q    <= prog_len_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_oob_q   <= fetch_oob_d;
            fetch_err_q   <= fetch_err_d;
            data_zero_q   <= data_zero_d;
        end
    end

    sp_ram_1w1r #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (load_ptr_q),
        .wr_data_i (bus.load_data),
        .rd_en_i   (fetch_acc),
        .rd_addr_i (bus.fetch_addr),
        .rd_data_o (rd_data)
    );

    // The RAM read register only updates on accepted fetches, so it already
    // holds; data_zero_q forces zero after reset or a rejected request.
    assign bus.load_ready  = (state_q == PM_LOADING);
    assign bus.ready       = (state_q == PM_READY);
    assign bus.prog_len    = prog_len_q;
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.fetch_oob   = fetch_oob_q;
    assign bus.fetch_err   = fetch_err_q;
    assign bus.fetch_data  = data_zero_q ? '0 : rd_data;

endmodule

// File: doc/prog_mem.md
# prog_mem

Parametrised, loadable program memory for the lab CPU; the successor to the fixed-content 32-word instruction ROM. It replaces the combinational, hard-initialised table with a clocked RAM. The RAM is filled at run time through a streaming load port with a valid/ready handshake, and instructions are served to the fetch stage through a registered request/response port. It sits between the bootstrap/testbench loader and the CPU fetch stage.

## Interface
- DATA_WIDTH, `INSTRUCTION_WIDTH: instruction word width.
- ADDR_WIDTH, 5: address width; DEPTH = 2**ADDR_WIDTH words.
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  reset; synchronous and active-high.
- load_start  in  1  pulse: begin (or restart) a program load at address 0.
- load_valid  in  1  load_data is valid this cycle.
- load_data  in  DATA_WIDTH  instruction word to store.
- load_last  in  1  qualifies the final word of the program (with load_valid).
- load_ready  out  1  memory accepts a load word this cycle.
- prog_len  out  ADDR_WIDTH+1  number of words in the current program.
- ready  out  1  a complete program is loaded; fetches are served.
- fetch_req  in  1  fetch request.
- fetch_addr  in  ADDR_WIDTH  word address to fetch.
- fetch_valid  out  1  fetch_data valid (one cycle after an accepted request).
- fetch_data  out  DATA_WIDTH  fetched instruction.
- fetch_oob  out  1  the returned address was >= prog_len (data still returned).
- fetch_err  out  1  the request was rejected because ready was 0.

## Operation
- Three states: IDLE, LOADING and READY. Reset enters IDLE.
- IDLE -> LOADING on load_start. READY -> LOADING on load_start.
- LOADING -> LOADING on load_start: restart, with load_ptr cleared to 0 and prog_len cleared to 0.
- Entering LOADING: load_ptr = 0, prog_len = 0, ready = 0.
- LOADING: load_ready = 1. Each cycle with load_valid && load_ready writes mem[load_ptr] = load_data, increments load_ptr and increments prog_len.
- LOADING -> READY when an accepted word has load_last = 1, or when the accepted word is at load_ptr = DEPTH-1 (the pointer never wraps). prog_len then equals the number of words written (1..DEPTH).
- load_start takes priority over a load word in the same cycle; that word is dropped.
- READY: a fetch_req is accepted every cycle, back-to-back. fetch_data = mem[fetch_addr] as of the request cycle. fetch_oob = (fetch_addr >= prog_len).
- IDLE/LOADING: a fetch_req is rejected. The response cycle carries fetch_err = 1, fetch_valid = 0 and fetch_data = 0.
- load_start and fetch_req in the same READY cycle: the fetch is served from the pre-load contents, then the state becomes LOADING.
- Reset does not clear memory contents; only the control state is reset. Memory words are undefined until written.

## Timing
- Reset values: load_ready = 0, ready = 0, prog_len = 0, fetch_valid = 0, fetch_data = 0, fetch_oob = 0, fetch_err = 0.
- Fetch latency is exactly 1 cycle: request at edge N, response valid after edge N+1.
- fetch_valid, fetch_oob and fetch_err are single-cycle pulses per request.
- fetch_data holds its last value when fetch_valid = 0. The exception is a rejected request, which sets fetch_data to 0.
- load_ready rises the cycle after load_start is sampled. It falls the cycle after the terminating word is accepted, and ready rises in that same cycle.
- Load throughput is 1 word/cycle.
- rst asserted mid-load: the next state is IDLE and prog_len = 0. Words already written remain in memory. A fetch response pending at reset is discarded.

## Structure
- Shared package/include (alongside the opcode definitions): state encoding constants PM_IDLE, PM_LOADING, PM_READY, plus the default DATA_WIDTH/ADDR_WIDTH.
- One sub-module: sp_ram_1w1r. It is a DEPTH x DATA_WIDTH RAM with a synchronous write port and a registered read port. The write port is driven by the loader and the read port by fetch.
- Top level: FSM, load_ptr/prog_len counters, fetch response registers.

## Test plan
- Reset, then fetch_req at addr 3 -> the next cycle has fetch_err = 1, fetch_valid = 0, fetch_data = 0, ready = 0.
- Load 4 words 0x01, 0x02, 0x03, 0x04 with load_last on the 4th -> ready = 1, prog_len = 4. Fetch addrs 0..3 back-to-back -> 0x01..0x04 one cycle later each, fetch_oob = 0.
- Load 4 words as above, then fetch addr 5 -> fetch_valid = 1, fetch_oob = 1.
- Load DEPTH (32) words with load_last never asserted -> READY after word 31, prog_len = 32, load_ready = 0 afterwards.
- Load words 0..2, then load_start -> prog_len = 0. Reload 2 words with load_last -> prog_len = 2. Addr 0 returns the new word.
- rst after 3 accepted load words -> IDLE, prog_len = 0. A new 1-word load then gives prog_len = 1. Fetch addr 1 returns the word from before the reset, with fetch_oob = 1.
